// File: rtl/lock_sequencer_pkg.sv
// Shared types and widths for the combination lock: sequencer states,
// programming sub-phases and the digit/index widths used with comparator_store.
package lock_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 3;
    localparam int IDX_W      = 2;
    localparam int FAIL_W     = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_FAIL,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } state_e;

    typedef enum logic [1:0] {
        PH_WAIT,
        PH_STROBE,
        PH_HOLD
    } prog_phase_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_sequencer_rise_detect.sv
// Rising-edge detector for a level input; the registered copy resets to a
// configurable value so a level already high at reset release yields no edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/lock_sequencer.sv
// Control FSM for the combination lock: steps through digit entry, opens on a
// full match, reprograms the stored code while open and enforces a lockout.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 50_000_000,
    parameter int LOCKOUT_CYCLES = 250_000_000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enter_i,
    input  logic              prog_req_i,
    input  logic              compare_i,
    output logic [IDX_W-1:0]  code_no_o,
    output logic              program_o,
    output logic              unlocked_o,
    output logic              alarm_o,
    output logic [FAIL_W-1:0] fail_count_o
);

    localparam int TIMER_W = $clog2(maxInt(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  MAX_FAIL     = FAIL_W'(MAX_TRIES);

    state_e              state_q, state_d;
    prog_phase_e         phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                bad_q, bad_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                program_q, program_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                ev;
    logic                badNext;
    logic [FAIL_W-1:0]   failInc;

    rise_detect #(.RESET_VAL(1'b1)) u_enter_rise (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (enter_i),
        .rise_o  (ev)
    );

    assign badNext = bad_q | ~compare_i;
    assign failInc = (fail_q == MAX_FAIL) ? fail_q : fail_q + FAIL_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_ENTRY;
            phase_q    <= PH_WAIT;
            idx_q      <= '0;
            bad_q      <= 1'b0;
            fail_q     <= '0;
            timer_q    <= '0;
            program_q  <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            bad_q      <= bad_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            program_q  <= program_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        bad_d     = bad_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        program_d = 1'b0;

        case (state_q)
            // Every digit is consumed before judging, so a wrong digit never
            // reveals its position by cutting the attempt short.
            ST_ENTRY: begin
                if (ev) begin
                    bad_d = badNext;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        bad_d = 1'b0;
                        if (badNext) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                            timer_d = UNLOCK_LOAD;
                        end
                    end
                end
            end
            ST_FAIL: begin
                fail_d = failInc;
                idx_d  = '0;
                bad_d  = 1'b0;
                if (failInc == MAX_FAIL) begin
                    state_d = ST_LOCKOUT;
                    timer_d = LOCKOUT_LOAD;
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (prog_req_i) begin
                    state_d = ST_PROG;
                    phase_d = PH_WAIT;
                    idx_d   = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            // Strobe, then hold the index one more cycle so the store sees a
            // stable address and data after the write edge.
            ST_PROG: begin
                case (phase_q)
                    PH_WAIT: begin
                        if (ev) begin
                            phase_d   = PH_STROBE;
                            program_d = 1'b1;
                        end
                    end
                    PH_STROBE: phase_d = PH_HOLD;
                    PH_HOLD: begin
                        phase_d = PH_WAIT;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_ENTRY;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    default: phase_d = PH_WAIT;
                endcase
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTRY;
                phase_d = PH_WAIT;
                idx_d   = '0;
                bad_d   = 1'b0;
            end
        endcase

        unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROG);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    assign code_no_o    = idx_q;
    assign program_o    = program_q;
    assign unlocked_o   = unlocked_q;
    assign alarm_o      = alarm_q;
    assign fail_count_o = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer with a behavioural model of the
// comparator_store; stimulus queues expected observations, a monitor checks them.
module tb_lock_sequencer;
    import lock_pkg::*;

    localparam int MAX_TRIES = 3;
    localparam int UNLOCK    = 20;
    localparam int LOCKOUT   = 30;

    typedef enum int {K_FAILCNT, K_ALARM_ON, K_ALARM_OFF, K_UNLOCK_ON, K_UNLOCK_OFF, K_PROG} kind_e;
    typedef struct {
        kind_e kind;
        int    data;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic        progReq = 1'b0;
    logic [2:0]  codein = 3'b000;
    logic        compare;
    logic [1:0]  codeNo;
    logic        programP;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  failCount;

    logic [2:0]  mem0 = 3'b001;
    logic [2:0]  mem1 = 3'b010;
    logic [2:0]  mem2 = 3'b100;
    logic [2:0]  storedDigit;

    int   cyc = 0;
    int   lastEvEdge = 0;
    int   total = 0;
    int   bad = 0;
    obs_t sbQ[$];

    lock_sequencer #(
        .MAX_TRIES      (MAX_TRIES),
        .UNLOCK_CYCLES  (UNLOCK),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enter_i      (enter),
        .prog_req_i   (progReq),
        .compare_i    (compare),
        .code_no_o    (codeNo),
        .program_o    (programP),
        .unlocked_o   (unlocked),
        .alarm_o      (alarm),
        .fail_count_o (failCount)
    );

    // Free-running clock and edge counter used for latency measurements
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural comparator_store: no reset, written while the strobe is high
    always_comb begin
        case (codeNo)
            2'd0:    storedDigit = mem0;
            2'd1:    storedDigit = mem1;
            2'd2:    storedDigit = mem2;
            default: storedDigit = 3'bxxx;
        endcase
    end
    assign compare = (codeNo != 2'd3) && (storedDigit == codein);

    always @(posedge clk) begin
        if (programP) begin
            case (codeNo)
                2'd0:    mem0 <= codein;
                2'd1:    mem1 <= codein;
                2'd2:    mem2 <= codein;
                default: ;
            endcase
        end
    end

    function automatic int progWord(input int lat, input int w, input bit hold,
                                    input logic [1:0] c, input logic [2:0] d);
        return (lat << 12) | (w << 8) | (int'(hold) << 7) | (int'(c) << 4) | int'(d);
    endfunction

    task automatic pushExpect(input kind_e k, input int d);
        obs_t o;
        o.kind = k;
        o.data = d;
        sbQ.push_back(o);
    endtask

    // Monitor side of the scoreboard: pop the oldest expectation and compare
    task automatic observe(input kind_e k, input int d);
        obs_t e;
        total++;
        if (sbQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected %s: got data=%0d want nothing queued", k.name(), d);
        end else begin
            e = sbQ.pop_front();
            if (e.kind != k || (e.data >= 0 && e.data != d)) begin
                bad++;
                $display("[TB] FAIL scoreboard: got %s data=%0d want %s data=%0d",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic tickN(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One entry event: set switches, wait a cycle, pulse enter for one cycle
    task automatic applyStimulus(input logic [2:0] d);
        codein = d;
        tickN(1);
        lastEvEdge = cyc + 1;
        enter = 1'b1;
        tickN(1);
        enter = 1'b0;
        tickN(3);
    endtask

    task automatic enterCode(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
    endtask

    // Monitor: turn output transitions into observations, sampled on negedge
    logic [1:0] prevFail = 2'd0;
    logic       prevAlarm = 1'b0;
    logic       prevUnlock = 1'b0;
    logic       prevProg = 1'b0;
    int         alarmLen = 0;
    int         unlockLen = 0;
    int         progLat = 0;
    int         progW = 0;
    logic [1:0] progCode = 2'd0;
    logic [2:0] progIn = 3'd0;

    always @(negedge clk) begin
        if (failCount != prevFail) observe(K_FAILCNT, int'(failCount));
        if (alarm && !prevAlarm) begin
            observe(K_ALARM_ON, cyc - lastEvEdge + 1);
            alarmLen = 0;
        end
        if (alarm) alarmLen++;
        if (!alarm && prevAlarm) observe(K_ALARM_OFF, alarmLen);
        if (unlocked && !prevUnlock) begin
            observe(K_UNLOCK_ON, cyc - lastEvEdge + 1);
            unlockLen = 0;
        end
        if (unlocked) unlockLen++;
        if (!unlocked && prevUnlock) observe(K_UNLOCK_OFF, unlockLen);
        if (programP && !prevProg) begin
            progLat  = cyc - lastEvEdge + 1;
            progW    = 0;
            progCode = codeNo;
            progIn   = codein;
        end
        if (programP) progW++;
        if (!programP && prevProg)
            observe(K_PROG, progWord(progLat, progW,
                                     (codeNo == progCode) && (codein == progIn),
                                     progCode, progIn));
        prevFail   = failCount;
        prevAlarm  = alarm;
        prevUnlock = unlocked;
        prevProg   = programP;
    end

    // Directed sequence; each step queues what the monitor must see
    initial begin
        int openEdge;

        reset = 1'b1;
        enter = 1'b1;
        tickN(3);
        checkOutput("reset code_no", int'(codeNo), 0);
        checkOutput("reset program", int'(programP), 0);
        checkOutput("reset unlocked", int'(unlocked), 0);
        checkOutput("reset alarm", int'(alarm), 0);
        checkOutput("reset fail_count", int'(failCount), 0);
        reset = 1'b0;
        tickN(3);
        enter = 1'b0;
        tickN(2);
        checkOutput("enter held over reset", int'(codeNo), 0);

        $display("[TB] correct code opens for UNLOCK cycles");
        pushExpect(K_UNLOCK_ON, 1);
        pushExpect(K_UNLOCK_OFF, UNLOCK);
        enterCode(3'b001, 3'b010, 3'b100);
        tickN(UNLOCK + 3);
        checkOutput("open fail_count", int'(failCount), 0);
        checkOutput("relocked", int'(unlocked), 0);

        $display("[TB] wrong middle digit");
        applyStimulus(3'b001);
        applyStimulus(3'b111);
        checkOutput("no early abort code_no", int'(codeNo), 2);
        checkOutput("no early abort fail_count", int'(failCount), 0);
        pushExpect(K_FAILCNT, 1);
        applyStimulus(3'b100);
        checkOutput("after fail code_no", int'(codeNo), 0);
        checkOutput("after fail unlocked", int'(unlocked), 0);

        $display("[TB] lockout after MAX_TRIES");
        pushExpect(K_FAILCNT, 2);
        enterCode(3'b111, 3'b111, 3'b111);
        tickN(2);
        pushExpect(K_FAILCNT, 3);
        pushExpect(K_ALARM_ON, 2);
        pushExpect(K_FAILCNT, 0);
        pushExpect(K_ALARM_OFF, LOCKOUT);
        enterCode(3'b000, 3'b000, 3'b000);
        checkOutput("lockout alarm", int'(alarm), 1);
        applyStimulus(3'b001);
        applyStimulus(3'b010);
        progReq = 1'b1;
        tickN(1);
        progReq = 1'b0;
        tickN(1);
        checkOutput("lockout ignores ev", int'(codeNo), 0);
        checkOutput("lockout stays locked", int'(unlocked), 0);
        tickN(LOCKOUT);
        checkOutput("lockout over alarm", int'(alarm), 0);
        pushExpect(K_UNLOCK_ON, 1);
        enterCode(3'b001, 3'b010, 3'b100);

        $display("[TB] reprogram to 110,011,101");
        progReq = 1'b1;
        tickN(1);
        progReq = 1'b0;
        tickN(1);
        pushExpect(K_PROG, progWord(1, 1, 1'b1, 2'd0, 3'b110));
        pushExpect(K_PROG, progWord(1, 1, 1'b1, 2'd1, 3'b011));
        pushExpect(K_PROG, progWord(1, 1, 1'b1, 2'd2, 3'b101));
        pushExpect(K_UNLOCK_OFF, -1);
        enterCode(3'b110, 3'b011, 3'b101);
        tickN(3);
        checkOutput("after prog unlocked", int'(unlocked), 0);
        checkOutput("after prog code_no", int'(codeNo), 0);
        pushExpect(K_UNLOCK_ON, 1);
        pushExpect(K_UNLOCK_OFF, UNLOCK);
        enterCode(3'b110, 3'b011, 3'b101);
        tickN(UNLOCK + 2);
        pushExpect(K_FAILCNT, 1);
        enterCode(3'b001, 3'b010, 3'b100);
        tickN(2);

        $display("[TB] prog_req on timer expiry, then reset mid-PROG");
        pushExpect(K_FAILCNT, 0);
        pushExpect(K_UNLOCK_ON, 1);
        enterCode(3'b110, 3'b011, 3'b101);
        openEdge = lastEvEdge;
        while (cyc < openEdge + UNLOCK - 1) tickN(1);
        progReq = 1'b1;
        tickN(1);
        progReq = 1'b0;
        tickN(2);
        checkOutput("prog wins over expiry", int'(unlocked), 1);
        pushExpect(K_PROG, progWord(1, 1, 1'b1, 2'd0, 3'b111));
        pushExpect(K_UNLOCK_OFF, -1);
        applyStimulus(3'b111);
        reset = 1'b1;
        tickN(2);
        checkOutput("mid-prog reset code_no", int'(codeNo), 0);
        checkOutput("mid-prog reset program", int'(programP), 0);
        checkOutput("mid-prog reset unlocked", int'(unlocked), 0);
        checkOutput("mid-prog reset alarm", int'(alarm), 0);
        checkOutput("mid-prog reset fail_count", int'(failCount), 0);
        reset = 1'b0;
        tickN(2);
        pushExpect(K_UNLOCK_ON, 1);
        pushExpect(K_UNLOCK_OFF, UNLOCK);
        enterCode(3'b111, 3'b011, 3'b101);
        tickN(UNLOCK + 2);
        pushExpect(K_FAILCNT, 1);
        enterCode(3'b110, 3'b011, 3'b101);
        tickN(4);

        checkOutput("scoreboard drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
